// File: rtl/stopwatch_lap_core_pkg.sv
// Shared definitions for the stopwatch/lap core.
// Defines the packed 24-bit time word {hour, min, sec, msec}, its field
// maxima, the run state encoding, and the preset saturation helper.
package stopwatch_lap_core_pkg;

    localparam int TIME_W = 24;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int MSEC_W = 7;

    localparam logic [MSEC_W-1:0] MSEC_MAX = 7'd99;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    // Field order fixes the bit positions: hour[23:19], min[18:13],
    // sec[12:7], msec[6:0].
    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MSEC_W-1:0] msec;
    } time_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } sw_state_t;

    // Clamp each field of a preset to its legal maximum.
    function automatic time_t sat_time(input time_t t);
        time_t r;
        r = t;
        if (t.msec > MSEC_MAX) r.msec = MSEC_MAX;
        if (t.sec  > SEC_MAX)  r.sec  = SEC_MAX;
        if (t.min  > MIN_MAX)  r.min  = MIN_MAX;
        if (t.hour > HOUR_MAX) r.hour = HOUR_MAX;
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_lap_core_lap_fifo.sv
// Lap capture FIFO: show-ahead read, overwrite-oldest when full.
// Ports: clk/reset (sync, active-high), i_flush empties the FIFO,
// i_push/i_data write an entry, i_pop removes the head (ignored when empty),
// o_head is the head entry (0 when empty), o_valid/o_full/o_count give
// occupancy decoded from the registered pointers and count.
module stopwatch_lap_core_lap_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 24,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic             o_full,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             empty, full, do_pop;

    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CW'(DEPTH));
    assign do_pop = i_pop && !empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (i_flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_q] = i_data;
                wr_d        = wr_q + 1'b1;
            end
            // A push into a full FIFO retires the oldest entry, so the read
            // pointer advances exactly as if it had been popped.
            if (do_pop || (i_push && full)) rd_d = rd_q + 1'b1;
            if (i_push && !do_pop && !full) cnt_d = cnt_q + 1'b1;
            else if (do_pop && !i_push)     cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the head output is masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_head  = empty ? '0 : mem_q[rd_q];
    assign o_valid = !empty;
    assign o_full  = full;
    assign o_count = cnt_q;

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch/timer core: up/down centisecond counter with run state machine,
// countdown expiry, saturated preset load and a lap-capture FIFO.
// Ports: clk/reset (sync, active-high); one-cycle button pulses i_run_stop,
// i_clear, i_load, i_lap; i_lap_rd pops the lap head; i_mode selects
// count direction (1 = down); i_load_time is the preset word.
// Outputs: o_time (packed time), o_running, o_expired/o_wrap pulses, and the
// lap FIFO head/valid/full/count.
module stopwatch_lap_core
    import stopwatch_lap_core_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_run_stop,
    input  logic                         i_clear,
    input  logic                         i_mode,
    input  logic                         i_load,
    input  logic [TIME_W-1:0]            i_load_time,
    input  logic                         i_lap,
    input  logic                         i_lap_rd,
    output logic [TIME_W-1:0]            o_time,
    output logic                         o_running,
    output logic                         o_expired,
    output logic                         o_wrap,
    output logic [TIME_W-1:0]            o_lap_time,
    output logic                         o_lap_valid,
    output logic                         o_lap_full,
    output logic [$clog2(LAP_DEPTH):0]   o_lap_count
);

    localparam int TICK_DIV = CLK_FREQ / 100;
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    sw_state_t        state_q, state_d;
    time_t            time_q, time_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;
    logic             wrap_q, wrap_d;
    logic             tick, lap_push, lap_pop;

    assign tick = (state_q == ST_RUN) && (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        div_d     = div_q;
        expired_d = 1'b0;
        wrap_d    = 1'b0;
        if (i_clear) begin
            state_d = ST_IDLE;
            time_d  = '0;
            div_d   = '0;
        end else if (i_load && (state_q != ST_RUN)) begin
            time_d  = sat_time(i_load_time);
            state_d = ST_PAUSE;
            div_d   = '0;
        end else if (i_run_stop) begin
            unique case (state_q)
                // IDLE always holds zero, so starting a countdown from it
                // expires straight away.
                ST_IDLE: begin
                    if (i_mode) begin
                        state_d   = ST_EXPIRED;
                        expired_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN:     state_d = ST_PAUSE;
                ST_PAUSE:   state_d = ST_RUN;
                ST_EXPIRED: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end else if (tick) begin
            div_d = '0;
            if (!i_mode) begin
                if (time_q.msec != MSEC_MAX) begin
                    time_d.msec = time_q.msec + 1'b1;
                end else begin
                    time_d.msec = '0;
                    if (time_q.sec != SEC_MAX) begin
                        time_d.sec = time_q.sec + 1'b1;
                    end else begin
                        time_d.sec = '0;
                        if (time_q.min != MIN_MAX) begin
                            time_d.min = time_q.min + 1'b1;
                        end else begin
                            time_d.min = '0;
                            if (time_q.hour != HOUR_MAX) begin
                                time_d.hour = time_q.hour + 1'b1;
                            end else begin
                                time_d.hour = '0;
                                wrap_d      = 1'b1;
                            end
                        end
                    end
                end
            end else begin
                if (time_q.msec != '0) begin
                    time_d.msec = time_q.msec - 1'b1;
                end else if (time_q != '0) begin
                    time_d.msec = MSEC_MAX;
                    if (time_q.sec != '0) begin
                        time_d.sec = time_q.sec - 1'b1;
                    end else begin
                        time_d.sec = SEC_MAX;
                        if (time_q.min != '0) begin
                            time_d.min = time_q.min - 1'b1;
                        end else begin
                            time_d.min  = MIN_MAX;
                            time_d.hour = time_q.hour - 1'b1;
                        end
                    end
                end
                // Reaching zero (or a countdown resumed at zero) stops
                // the timer instead of borrowing below zero.
                if (time_d == '0) begin
                    state_d   = ST_EXPIRED;
                    expired_d = 1'b1;
                end
            end
        end else if (state_q == ST_RUN) begin
            div_d = div_q + 1'b1;
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            time_q    <= '0;
            div_q     <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            div_q     <= div_d;
            running_q <= running_d;
            expired_q <= expired_d;
            wrap_q    <= wrap_d;
        end
    end

    // Clear empties the FIFO, overriding any same-cycle lap or read.
    assign lap_push = i_lap && (state_q == ST_RUN) && !i_clear;
    assign lap_pop  = i_lap_rd && !i_clear;

    stopwatch_lap_core_lap_fifo #(
        .DEPTH (LAP_DEPTH),
        .WIDTH (TIME_W)
    ) u_lap_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (i_clear),
        .i_push  (lap_push),
        .i_pop   (lap_pop),
        .i_data  (time_q),
        .o_head  (o_lap_time),
        .o_valid (o_lap_valid),
        .o_full  (o_lap_full),
        .o_count (o_lap_count)
    );

    assign o_time    = time_q;
    assign o_running = running_q;
    assign o_expired = expired_q;
    assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Testbench for stopwatch_lap_core: directed scenarios plus random pulses,
// all checked every cycle against a reference model that keeps time as a
// single centisecond total and the lap FIFO as a queue.
module tb_stopwatch_lap_core;

    localparam int CLK_FREQ  = 1000;
    localparam int LAP_DEPTH = 4;
    localparam int TICK_DIV  = CLK_FREQ / 100;
    localparam int DAY_CS    = 24 * 60 * 60 * 100;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_PAUSE = 2;
    localparam int S_EXP  = 3;

    logic        clk = 1'b0;
    logic        reset, i_run_stop, i_clear, i_mode, i_load, i_lap, i_lap_rd;
    logic [23:0] i_load_time;
    logic [23:0] o_time, o_lap_time;
    logic        o_running, o_expired, o_wrap, o_lap_valid, o_lap_full;
    logic [2:0]  o_lap_count;

    always #5 clk = ~clk;

    stopwatch_lap_core #(
        .CLK_FREQ  (CLK_FREQ),
        .LAP_DEPTH (LAP_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_run_stop  (i_run_stop),
        .i_clear     (i_clear),
        .i_mode      (i_mode),
        .i_load      (i_load),
        .i_load_time (i_load_time),
        .i_lap       (i_lap),
        .i_lap_rd    (i_lap_rd),
        .o_time      (o_time),
        .o_running   (o_running),
        .o_expired   (o_expired),
        .o_wrap      (o_wrap),
        .o_lap_time  (o_lap_time),
        .o_lap_valid (o_lap_valid),
        .o_lap_full  (o_lap_full),
        .o_lap_count (o_lap_count)
    );

    // Reference model state
    int m_st, m_div, m_t;
    bit m_exp, m_wrap;
    int m_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int wrap_seen, exp_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 25)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [23:0] pack(input int t);
        return {5'(t / 360000), 6'((t / 6000) % 60), 6'((t / 100) % 60), 7'(t % 100)};
    endfunction

    function automatic int preset_cs(input logic [23:0] w);
        int h, m, s, c;
        h = int'(w[23:19]); m = int'(w[18:13]); s = int'(w[12:7]); c = int'(w[6:0]);
        if (h > 23) h = 23;
        if (m > 59) m = 59;
        if (s > 59) s = 59;
        if (c > 99) c = 99;
        return h * 360000 + m * 6000 + s * 100 + c;
    endfunction

    task automatic model_step();
        bit tick;
        m_exp  = 0;
        m_wrap = 0;
        if (reset) begin
            m_st = S_IDLE; m_t = 0; m_div = 0;
            m_q.delete();
        end else begin
            tick = (m_st == S_RUN) && (m_div == TICK_DIV - 1);
            if (i_clear) begin
                m_q.delete();
            end else begin
                if (i_lap_rd && m_q.size() > 0) void'(m_q.pop_front());
                if (i_lap && m_st == S_RUN) begin
                    m_q.push_back(m_t);
                    if (m_q.size() > LAP_DEPTH) void'(m_q.pop_front());
                end
            end
            if (i_clear) begin
                m_st = S_IDLE; m_t = 0; m_div = 0;
            end else if (i_load && m_st != S_RUN) begin
                m_t = preset_cs(i_load_time); m_st = S_PAUSE; m_div = 0;
            end else if (i_run_stop) begin
                case (m_st)
                    S_IDLE:  if (i_mode) begin m_st = S_EXP; m_exp = 1; end else m_st = S_RUN;
                    S_RUN:   m_st = S_PAUSE;
                    S_PAUSE: m_st = S_RUN;
                    default: m_st = S_IDLE;
                endcase
            end else if (tick) begin
                m_div = 0;
                if (!i_mode) begin
                    m_t = m_t + 1;
                    if (m_t == DAY_CS) begin m_t = 0; m_wrap = 1; end
                end else begin
                    if (m_t > 0) m_t = m_t - 1;
                    if (m_t == 0) begin m_st = S_EXP; m_exp = 1; end
                end
            end else if (m_st == S_RUN) begin
                m_div = m_div + 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("time",      32'(o_time),      32'(pack(m_t)));
        chk("running",   32'(o_running),   32'(m_st == S_RUN));
        chk("expired",   32'(o_expired),   32'(m_exp));
        chk("wrap",      32'(o_wrap),      32'(m_wrap));
        chk("lap_valid", 32'(o_lap_valid), 32'(m_q.size() != 0));
        chk("lap_full",  32'(o_lap_full),  32'(m_q.size() == LAP_DEPTH));
        chk("lap_count", 32'(o_lap_count), 32'(m_q.size()));
        chk("lap_time",  32'(o_lap_time),  (m_q.size() != 0) ? 32'(pack(m_q[0])) : 32'd0);
        if (o_wrap)    wrap_seen++;
        if (o_expired) exp_seen++;
    endtask

    task automatic step(input bit rs, input bit clr, input bit ld, input bit lap,
                        input bit rd, input logic [23:0] lt);
        i_run_stop = rs; i_clear = clr; i_load = ld; i_lap = lap; i_lap_rd = rd;
        i_load_time = lt;
        @(posedge clk);
        model_step();
        @(negedge clk);
        i_run_stop = 0; i_clear = 0; i_load = 0; i_lap = 0; i_lap_rd = 0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 24'h0);
    endtask

    logic [23:0] w_almost, w_sat, w_rand;

    initial begin
        reset = 1; i_mode = 0;
        i_run_stop = 0; i_clear = 0; i_load = 0; i_lap = 0; i_lap_rd = 0;
        i_load_time = '0;
        wrap_seen = 0; exp_seen = 0;
        m_st = S_IDLE; m_t = 0; m_div = 0;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 24'h0);
        step(0, 0, 0, 0, 0, 24'h0);
        reset = 0;
        chk("rst_time", 32'(o_time), 32'd0);
        chk("rst_count", 32'(o_lap_count), 32'd0);

        // Up count, 1000 ticks -> 00:00:10:00, then pause holds
        step(1, 0, 0, 0, 0, 24'h0);
        idle(1000 * TICK_DIV);
        chk("up_10s", 32'(o_time), 32'h000500);
        chk("up_running", 32'(o_running), 32'd1);
        step(1, 0, 0, 0, 0, 24'h0);
        idle(50);
        chk("pause_hold", 32'(o_time), 32'h000500);

        // Wrap from 23:59:59:98
        w_almost = {5'd23, 6'd59, 6'd59, 7'd98};
        step(0, 0, 1, 0, 0, w_almost);
        step(1, 0, 0, 0, 0, 24'h0);
        wrap_seen = 0;
        idle(2 * TICK_DIV);
        chk("wrap_time", 32'(o_time), 32'd0);
        chk("wrap_pulse", 32'(o_wrap), 32'd1);
        chk("wrap_once", 32'(wrap_seen), 32'd1);

        // Countdown from 3 centiseconds
        step(1, 0, 0, 0, 0, 24'h0);
        step(0, 0, 1, 0, 0, 24'h000003);
        i_mode = 1;
        step(1, 0, 0, 0, 0, 24'h0);
        exp_seen = 0;
        idle(3 * TICK_DIV);
        chk("cd_time", 32'(o_time), 32'd0);
        chk("cd_expired", 32'(o_expired), 32'd1);
        chk("cd_stopped", 32'(o_running), 32'd0);
        idle(3 * TICK_DIV);
        chk("cd_hold", 32'(o_time), 32'd0);
        chk("cd_once", 32'(exp_seen), 32'd1);

        // Six laps into a four-entry FIFO
        i_mode = 0;
        step(0, 1, 0, 0, 0, 24'h0);
        step(1, 0, 0, 0, 0, 24'h0);
        idle(TICK_DIV);
        for (int k = 1; k <= 6; k++) begin
            step(0, 0, 0, 1, 0, 24'h0);
            idle(TICK_DIV - 1);
        end
        chk("lap_cnt4", 32'(o_lap_count), 32'd4);
        chk("lap_full", 32'(o_lap_full), 32'd1);
        chk("lap_head3", 32'(o_lap_time), 32'd3);
        step(0, 0, 0, 1, 1, 24'h0);
        chk("lap_pushpop_cnt", 32'(o_lap_count), 32'd4);
        chk("lap_pushpop_head", 32'(o_lap_time), 32'd4);

        // Saturated preset, and load ignored while running
        w_sat = {5'd23, 6'd59, 6'd59, 7'd99};
        step(1, 0, 0, 0, 0, 24'h0);
        step(0, 0, 1, 0, 0, 24'hFFFFFF);
        chk("load_sat", 32'(o_time), 32'(w_sat));
        step(1, 0, 0, 0, 0, 24'h0);
        step(0, 0, 1, 0, 0, 24'h000000);
        chk("load_in_run", 32'(o_time), 32'(w_sat));

        // Clear with run_stop and lap in the same cycle
        step(1, 1, 0, 1, 0, 24'h0);
        chk("clr_time", 32'(o_time), 32'd0);
        chk("clr_running", 32'(o_running), 32'd0);
        chk("clr_count", 32'(o_lap_count), 32'd0);
        chk("clr_valid", 32'(o_lap_valid), 32'd0);

        // Random pulses
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) == 0) i_mode = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 399) == 0);
            w_rand = 24'($urandom());
            if ($urandom_range(0, 1) == 0)
                w_rand = pack(int'($urandom_range(0, 300)));
            step($urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, w_rand);
            reset = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
